// File: rtl/hazard_fwd_if.sv
// ID-side hazard/forwarding bundle: decoded fields and EX flush in, stall and
// forwarding-mux selects out.
interface hazard_fwd_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              ex_flush;
  logic              stall;
  logic [1:0]        ex_fwd_a_sel;
  logic [1:0]        ex_fwd_b_sel;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, ex_flush,
    input  stall, ex_fwd_a_sel, ex_fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, ex_flush,
    output stall, ex_fwd_a_sel, ex_fwd_b_sel, stall_count
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: shadows EX/MEM destinations, registers the
// EX operand-mux selects and raises a one-cycle load-use stall.
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_fwd_if.slave  bus
);

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_WB  = 2'b01,
    SEL_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
  } shadow_t;

  localparam shadow_t          BUBBLE  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The WB occupant is never tracked: the write-through register file already
  // returns its result to the ID read, so only EX and MEM can need a bypass.
  shadow_t          r_ex;
  shadow_t          r_mem;
  fwd_sel_e         r_sel_a;
  fwd_sel_e         r_sel_b;
  logic [CNT_W-1:0] r_stall_count;

  shadow_t          w_id_entry;
  logic             w_load_use;
  logic             w_stall;
  logic             w_advance;
  fwd_sel_e         w_sel_a;
  fwd_sel_e         w_sel_b;

  // Current EX becomes MEM and current MEM becomes WB by the time the ID
  // instruction executes, so EX maps to the MEM bypass and MEM to the WB one.
  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs,
                                       input shadow_t           ex,
                                       input shadow_t           mem);
    fwd_sel_e sel;
    sel = SEL_RF;
    if (ex.rw && (ex.rd != '0) && (ex.rd == rs))
      sel = SEL_MEM;
    else if (mem.rw && (mem.rd != '0) && (mem.rd == rs))
      sel = SEL_WB;
    return sel;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_id_entry    = BUBBLE;
    w_id_entry.rd = bus.id_rd;
    w_id_entry.rw = bus.id_regwrite;
    w_id_entry.mr = bus.id_memread;

    // Both rs fields are compared whatever the format: a false stall only
    // costs a cycle, a missed one corrupts an operand.
    w_load_use = r_ex.mr && (r_ex.rd != '0) &&
                 ((r_ex.rd == bus.id_rs1) || (r_ex.rd == bus.id_rs2));
    w_stall    = bus.id_valid && !bus.ex_flush && w_load_use;
    w_advance  = bus.id_valid && !bus.ex_flush && !w_stall;

    w_sel_a = SEL_RF;
    w_sel_b = SEL_RF;
    if (w_advance) begin
      w_sel_a = fwd_sel(bus.id_rs1, r_ex, r_mem);
      w_sel_b = fwd_sel(bus.id_rs2, r_ex, r_mem);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, like real flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex          <= BUBBLE;
      r_mem         <= BUBBLE;
      r_sel_a       <= SEL_RF;
      r_sel_b       <= SEL_RF;
      r_stall_count <= '0;
    end else begin
      r_mem   <= r_ex;
      r_ex    <= w_advance ? w_id_entry : BUBBLE;
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
      if (w_stall && (r_stall_count != CNT_MAX))
        r_stall_count <= r_stall_count + CNT_ONE;
    end
  end

  assign bus.stall        = w_stall;
  assign bus.ex_fwd_a_sel = r_sel_a;
  assign bus.ex_fwd_b_sel = r_sel_b;
  assign bus.stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: per-cycle vector table, scoreboard
// queue for the registered selects, plus saturation and mid-run reset sequences.
module tb_hazard_fwd_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  typedef struct {
    bit       vld;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
    bit       fl;
    bit       exp_stall;
    bit [1:0] exp_a;
    bit [1:0] exp_b;
  } vec_t;

  typedef struct {
    bit [1:0] a;
    bit [1:0] b;
  } sel_exp_t;

  logic clk;
  logic rst_n;

  hazard_fwd_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  hazard_fwd_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int              checks;
  int              errors;
  sel_exp_t        sb[$];
  bit [CNT_W-1:0]  model_cnt;
  vec_t            tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t vr(bit vld, int rs1, int rs2, int rd, bit rw, bit mr,
                              bit fl, bit st, int a, int b);
    vec_t v;
    v.vld = vld;  v.rs1 = 5'(rs1);  v.rs2 = 5'(rs2);  v.rd = 5'(rd);
    v.rw  = rw;   v.mr  = mr;       v.fl  = fl;       v.exp_stall = st;
    v.exp_a = 2'(a);  v.exp_b = 2'(b);
    return v;
  endfunction

  function automatic vec_t nop();
    return vr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic drive(input vec_t v);
    bus.id_valid    = v.vld;
    bus.id_rs1      = v.rs1;
    bus.id_rs2      = v.rs2;
    bus.id_rd       = v.rd;
    bus.id_regwrite = v.rw;
    bus.id_memread  = v.mr;
    bus.ex_flush    = v.fl;
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 unit after the next.
  task automatic step(input string tag, input vec_t v);
    sel_exp_t e;
    drive(v);
    #1;
    check({tag, "_stall"}, bus.stall, v.exp_stall);
    e.a = v.exp_a;
    e.b = v.exp_b;
    sb.push_back(e);
    if (v.exp_stall && (model_cnt != '1))
      model_cnt = model_cnt + 1'b1;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, "_a_sel"}, bus.ex_fwd_a_sel, e.a);
    check({tag, "_b_sel"}, bus.ex_fwd_b_sel, e.b);
    check({tag, "_count"}, bus.stall_count, model_cnt);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_cnt = '0;
    rst_n     = 1'b0;
    drive(nop());
    #12;
    check("rst_stall", bus.stall, 1'b0);
    check("rst_a_sel", bus.ex_fwd_a_sel, 2'b00);
    check("rst_b_sel", bus.ex_fwd_b_sel, 2'b00);
    check("rst_count", bus.stall_count, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) tbl.push_back(nop());
    // ADD x5 ; SUB x5,x5 -> both from MEM bypass
    tbl.push_back(vr(1, 1, 2, 5, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vr(1, 5, 5, 6, 1, 0, 0, 0, 2, 2));
    tbl.push_back(nop()); tbl.push_back(nop());
    // ADD x5 ; NOP ; AND x6,x5 -> b from WB bypass
    tbl.push_back(vr(1, 1, 2, 5, 1, 0, 0, 0, 0, 0));
    tbl.push_back(nop());
    tbl.push_back(vr(1, 6, 5, 8, 1, 0, 0, 0, 0, 1));
    tbl.push_back(nop()); tbl.push_back(nop());
    // ADD x7 ; ADD x7 ; OR x7,x0 -> youngest producer wins
    tbl.push_back(vr(1, 1, 2, 7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vr(1, 3, 4, 7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(vr(1, 7, 0, 10, 1, 0, 0, 0, 2, 0));
    tbl.push_back(nop()); tbl.push_back(nop());
    // LW x9 ; ADD x1,x9 -> one stall, then WB bypass
    tbl.push_back(vr(1, 2, 3, 9, 1, 1, 0, 0, 0, 0));
    tbl.push_back(vr(1, 1, 9, 11, 1, 0, 0, 1, 0, 0));
    tbl.push_back(vr(1, 1, 9, 11, 1, 0, 0, 0, 0, 1));
    tbl.push_back(nop()); tbl.push_back(nop());
    // LW x9 ; ADD x9 with flush -> flush beats stall
    tbl.push_back(vr(1, 2, 3, 9, 1, 1, 0, 0, 0, 0));
    tbl.push_back(vr(1, 9, 1, 11, 1, 0, 1, 0, 0, 0));
    tbl.push_back(nop()); tbl.push_back(nop());
    // LW x0 ; ADD x0,x0 -> x0 never matches
    tbl.push_back(vr(1, 1, 2, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(vr(1, 0, 0, 12, 1, 0, 0, 0, 0, 0));
    tbl.push_back(nop()); tbl.push_back(nop());
    // flushed ADD x5 must not feed the following SUB
    tbl.push_back(vr(1, 1, 2, 5, 1, 0, 1, 0, 0, 0));
    tbl.push_back(vr(1, 5, 5, 6, 1, 0, 0, 0, 0, 0));
    tbl.push_back(nop()); tbl.push_back(nop());
    // LW x9 ; LW x10,(x9) ; ADD x4,x10 -> one stall per dependent pair
    tbl.push_back(vr(1, 1, 2, 9, 1, 1, 0, 0, 0, 0));
    tbl.push_back(vr(1, 9, 3, 10, 1, 1, 0, 1, 0, 0));
    tbl.push_back(vr(1, 9, 3, 10, 1, 1, 0, 0, 1, 0));
    tbl.push_back(vr(1, 4, 10, 13, 1, 0, 0, 1, 0, 0));
    tbl.push_back(vr(1, 4, 10, 13, 1, 0, 0, 0, 0, 1));
    tbl.push_back(nop()); tbl.push_back(nop());

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("row%0d", i), tbl[i]);

    // Saturation: 15 more load-use pairs push the 4-bit counter past all-ones.
    for (int k = 0; k < 15; k++) begin
      step($sformatf("sat%0d_lw", k),   vr(1, 2, 3, 9, 1, 1, 0, 0, 0, 0));
      step($sformatf("sat%0d_st", k),   vr(1, 9, 1, 11, 1, 0, 0, 1, 0, 0));
      step($sformatf("sat%0d_go", k),   vr(1, 9, 1, 11, 1, 0, 0, 0, 1, 0));
    end
    check("sat_hold", bus.stall_count, 4'hF);

    // Mid-run reset: a live MEM select and a load in EX must both vanish.
    step("mr_nop0", nop());
    step("mr_nop1", nop());
    step("mr_add",  vr(1, 1, 2, 5, 1, 0, 0, 0, 0, 0));
    step("mr_lw",   vr(1, 5, 5, 6, 1, 1, 0, 0, 2, 2));
    drive(vr(1, 6, 1, 14, 1, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_stall", bus.stall, 1'b0);
    check("mr_a_sel", bus.ex_fwd_a_sel, 2'b00);
    check("mr_b_sel", bus.ex_fwd_b_sel, 2'b00);
    check("mr_count", bus.stall_count, '0);
    model_cnt = '0;
    sb.delete();
    drive(nop());
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("mr_after", vr(1, 6, 5, 14, 1, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
